// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - push/pop and external RAM signal bundle for ram_fifo_ctrl (RAM_FIFO_CTRL_ERR_FLAGS_EN adds overflow/underflow)
interface ram_fifo_ctrl_if #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8
);
    localparam int AdrBits = $clog2(DEPTH);
    localparam int CntBits = $clog2(DEPTH + 1);

    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  full;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  empty;
    logic [CntBits-1:0]    count;
    logic                  ram_we;
    logic [AdrBits-1:0]    ram_w_addr;
    logic [DATA_WIDTH-1:0] ram_w_data;
    logic                  ram_re;
    logic [AdrBits-1:0]    ram_r_addr;
    logic [DATA_WIDTH-1:0] ram_r_data;
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport slave (
        input  push, push_data, pop, ram_r_data,
        output full, pop_data, empty, count,
        output ram_we, ram_w_addr, ram_w_data, ram_re, ram_r_addr
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );

    modport master (
        output push, push_data, pop, ram_r_data,
        input  full, pop_data, empty, count,
        input  ram_we, ram_w_addr, ram_w_data, ram_re, ram_r_addr
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FWFT FIFO controller for an external RAM (optional RAM_FIFO_CTRL_ERR_FLAGS_EN sticky error flags)
module ram_fifo_ctrl #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    ram_fifo_ctrl_if.slave bus
);
    localparam int AdrBits = $clog2(DEPTH);
    localparam int CntBits = $clog2(DEPTH + 1);

    logic [AdrBits-1:0] wr_ptr;
    logic [AdrBits-1:0] rd_ptr;
    logic [CntBits-1:0] cnt;
    logic               full_w;
    logic               empty_w;
    logic               push_acc;
    logic               pop_acc;

    // Explicit wrap so non-power-of-two depths address only valid entries
    function automatic logic [AdrBits-1:0] next_ptr(input logic [AdrBits-1:0] p);
        return (p == AdrBits'(DEPTH - 1)) ? '0 : p + AdrBits'(1);
    endfunction

    // Flags come straight from the count; a push into a full FIFO is refused even
    // alongside a pop, since wr_ptr == rd_ptr would let RAM forwarding corrupt the head
    always_comb begin
        full_w   = (cnt == CntBits'(DEPTH));
        empty_w  = (cnt == '0);
        push_acc = bus.push & ~full_w;
        pop_acc  = bus.pop & ~empty_w;
    end

    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.count      = cnt;
    assign bus.ram_we     = push_acc;
    assign bus.ram_w_addr = wr_ptr;
    assign bus.ram_w_data = bus.push_data;
    assign bus.ram_re     = ~empty_w;
    assign bus.ram_r_addr = rd_ptr;
    assign bus.pop_data   = bus.ram_r_data;

    // Pointer and occupancy bookkeeping for accepted requests
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_acc) wr_ptr <= next_ptr(wr_ptr);
            if (pop_acc)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + CntBits'(1);
                2'b01:   cnt <= cnt - CntBits'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky record of any refused push or pop, held until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.push & full_w) overflow_q  <= 1'b1;
            if (bus.pop & empty_w) underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - scoreboard bench for ram_fifo_ctrl against a queue model (RAM_FIFO_CTRL_ERR_FLAGS_EN aware)
module tb_ram_fifo_ctrl;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int AB    = $clog2(DEPTH);
    localparam int CB    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    ram_fifo_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External dual-port RAM: synchronous write, async read, same-address forwarding, 0 when not enabled
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_w_addr] <= bus.ram_w_data;
    end
    always_comb begin
        bus.ram_r_data = '0;
        if (bus.ram_re)
            bus.ram_r_data = (bus.ram_we && bus.ram_w_addr == bus.ram_r_addr) ? bus.ram_w_data
                                                                              : mem[bus.ram_r_addr];
    end

    typedef struct {
        logic [CB-1:0] cnt;
        logic          empty;
        logic          full;
        logic          we;
        logic          re;
        logic [AB-1:0] waddr;
        logic [AB-1:0] raddr;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          st_q[$];
    logic [DW-1:0] data_q[$];

    logic [DW-1:0] model_q[$];
    int            widx = 0;
    int            ridx = 0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each cycle's observable state and every accepted pop's data
    always @(negedge clk) begin
        exp_t e;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("count", 32'(bus.count), 32'(e.cnt));
            chk("empty", 32'(bus.empty), 32'(e.empty));
            chk("full", 32'(bus.full), 32'(e.full));
            chk("ram_we", 32'(bus.ram_we), 32'(e.we));
            chk("ram_re", 32'(bus.ram_re), 32'(e.re));
            chk("ram_w_addr", 32'(bus.ram_w_addr), 32'(e.waddr));
            chk("ram_r_addr", 32'(bus.ram_r_addr), 32'(e.raddr));
            if (e.empty) chk("pop_data_empty", 32'(bus.pop_data), 32'd0);
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
            chk("overflow", 32'(bus.overflow), 32'(e.ovf));
            chk("underflow", 32'(bus.underflow), 32'(e.unf));
`endif
            if (bus.pop && !bus.empty && !rst) begin
                if (data_q.size() == 0) begin
                    chk("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("pop_data", 32'(bus.pop_data), 32'(data_q.pop_front()));
                end
            end
        end
    end

    // One cycle of stimulus: drive, record expectations, advance the model, wait for the edge
    task automatic step(input logic p, input logic [DW-1:0] d, input logic q, input logic r);
        exp_t e;
        int   size;
        logic pacc;
        logic qacc;
        rst           = r;
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = q;
        size = model_q.size();
        pacc = p && (size < DEPTH);
        qacc = q && (size > 0);
        e.cnt   = CB'(size);
        e.empty = (size == 0);
        e.full  = (size == DEPTH);
        e.we    = pacc;
        e.re    = (size != 0);
        e.waddr = AB'(widx);
        e.raddr = AB'(ridx);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        st_q.push_back(e);
        if (r) begin
            model_q.delete();
            widx  = 0;
            ridx  = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (qacc) begin
                data_q.push_back(model_q.pop_front());
                ridx = (ridx + 1) % DEPTH;
            end
            if (pacc) begin
                model_q.push_back(d);
                widx = (widx + 1) % DEPTH;
            end
            if (p && size == DEPTH) m_ovf = 1'b1;
            if (q && size == 0)     m_unf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bias;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_data = '0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        // Fill with 0x11..0x44, then drain in order
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        // Wrap: push 3, pop 3, then 0xA5/0x5A across the wrap point
        for (int i = 0; i < 3; i++) step(1, 8'(i + 1), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
        step(1, 8'hA5, 0, 0);
        step(1, 8'h5A, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        // Full with simultaneous push and pop: push refused, pop served
        for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), 0, 0);
        step(1, 8'hEE, 1, 0);
        step(0, 8'h00, 0, 0);
        // Count 2 with simultaneous push and pop
        step(0, 8'h00, 1, 0);
        step(1, 8'h77, 1, 0);
        step(1, 8'h78, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        // Pop while empty, then overfill
        step(0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        // Reset mid-operation with requests present
        step(1, 8'hFF, 1, 1);
        step(0, 8'h00, 0, 0);

        // Randomized traffic with shifting push/pop balance
        for (int blk = 0; blk < 15; blk++) begin
            bias = int'($urandom_range(15, 85));
            for (int c = 0; c < 200; c++) begin
                step(($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0,
                     8'($urandom),
                     ($urandom_range(0, 99) < (100 - bias)) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            end
        end

        bus.push = 1'b0;
        bus.pop  = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        #1;
        chk("drain", 32'(data_q.size()), 32'd0);
        chk("status_drain", 32'(st_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
